// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline controller / PC sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'h0000_0004;

    typedef enum logic [1:0] {
        CTRL_BOOT  = 2'b00,
        CTRL_RUN   = 2'b01,
        CTRL_FLUSH = 2'b10
    } ctrl_state_e;

    // Redirect deferred while the bus is stalled.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } redirect_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & ADDR_W'(3)) != '0;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// EX-stage control / front-end interface between the execute stage and pipe_ctrl.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
();

    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              hold_flag_i;
    logic              bus_hold_i;
    logic [ADDR_W-1:0] pc_o;
    logic              flush_o;
    logic              hold_o;
    logic              misalign_o;

    modport master (
        output jump_en_i,
        output jump_addr_i,
        output hold_flag_i,
        output bus_hold_i,
        input  pc_o,
        input  flush_o,
        input  hold_o,
        input  misalign_o
    );

    modport slave (
        input  jump_en_i,
        input  jump_addr_i,
        input  hold_flag_i,
        input  bus_hold_i,
        output pc_o,
        output flush_o,
        output hold_o,
        output misalign_o
    );

endinterface

// File: rtl/pipe_ctrl_redirect_buf.sv
// Single-entry pending-redirect register: keeps only the first request seen while stalled.
module pipe_ctrl_redirect_buf
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              apply,
    input  logic              clear,
    output redirect_t         pend
);

    redirect_t pend_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
        end else if (apply || clear) begin
            pend_q.valid <= 1'b0;
        end else if (set && !pend_q.valid) begin
            pend_q.valid <= 1'b1;
            pend_q.addr  <= set_addr;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: owns the fetch PC, sequences boot, redirects and stalls,
// and drives flush/hold for the IF/ID and ID/EX registers.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned       BOOT_CYCLES  = 2,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BOOT_INIT  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam bit               FLUSH_EN   = (FLUSH_CYCLES > 1);

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;

    logic              flush_c;
    logic              hold_c;
    logic              redirect_c;
    logic [ADDR_W-1:0] redirect_addr_c;
    logic              pend_set_c;
    logic              pend_apply_c;
    logic              pend_clear_c;
    redirect_t         pend;

    pipe_ctrl_redirect_buf u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .set      (pend_set_c),
        .set_addr (bus.jump_addr_i),
        .apply    (pend_apply_c),
        .clear    (pend_clear_c),
        .pend     (pend)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CTRL_BOOT;
            cnt_q      <= BOOT_INIT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next state, PC and Mealy flush/hold; bus stall outranks everything outside boot.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_d            = pc_q;
        misalign_d      = 1'b0;
        flush_c         = 1'b0;
        hold_c          = 1'b0;
        redirect_c      = 1'b0;
        redirect_addr_c = bus.jump_addr_i;
        pend_set_c      = 1'b0;
        pend_apply_c    = 1'b0;
        pend_clear_c    = (state_q == CTRL_BOOT);

        case (state_q)
            CTRL_BOOT: begin
                flush_c = 1'b1;
                hold_c  = 1'b1;
                if (cnt_q == '0) begin
                    state_d = CTRL_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CTRL_RUN, CTRL_FLUSH: begin
                if (bus.bus_hold_i) begin
                    hold_c     = 1'b1;
                    pend_set_c = bus.jump_en_i;
                end else if (pend.valid) begin
                    redirect_c      = 1'b1;
                    redirect_addr_c = pend.addr;
                    pend_apply_c    = 1'b1;
                end else if (state_q == CTRL_RUN && bus.jump_en_i) begin
                    redirect_c = 1'b1;
                end else if (state_q == CTRL_FLUSH) begin
                    flush_c = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    if (cnt_q == '0) begin
                        state_d = CTRL_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (bus.hold_flag_i) begin
                    hold_c = 1'b1;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            default: begin
                state_d = CTRL_BOOT;
                cnt_d   = BOOT_INIT;
            end
        endcase

        if (redirect_c) begin
            flush_c    = 1'b1;
            pc_d       = align_pc(redirect_addr_c);
            misalign_d = misaligned(redirect_addr_c);
            if (FLUSH_EN) begin
                state_d = CTRL_FLUSH;
                cnt_d   = FLUSH_INIT;
            end else begin
                state_d = CTRL_RUN;
            end
        end

        // While reset is asserted the pipe regs are held flushed regardless of state.
        if (!rst) begin
            flush_c = 1'b1;
            hold_c  = 1'b1;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.flush_o    = flush_c;
    assign bus.hold_o     = hold_c;
    assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, redirects, holds, bus stalls, wrap and mid-run reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .BOOT_CYCLES  (2),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fh(input string tag, input logic f, input logic h);
        #1;
        chk({tag, ".flush"}, 32'(bus_if.flush_o), 32'(f));
        chk({tag, ".hold"},  32'(bus_if.hold_o),  32'(h));
    endtask

    task automatic drive(input logic je, input logic [31:0] ja, input logic hf, input logic bh);
        bus_if.jump_en_i   = je;
        bus_if.jump_addr_i = ja;
        bus_if.hold_flag_i = hf;
        bus_if.bus_hold_i  = bh;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset held for two edges
        cyc();
        chk("rst.pc", bus_if.pc_o, 32'h0);
        chk("rst.mis", 32'(bus_if.misalign_o), 32'h0);
        chk_fh("rst", 1'b1, 1'b1);
        cyc();
        rst = 1'b1;
        chk_fh("boot1", 1'b1, 1'b1);
        chk("boot1.pc", bus_if.pc_o, 32'h0);
        cyc();
        chk_fh("boot2", 1'b1, 1'b1);
        chk("boot2.pc", bus_if.pc_o, 32'h0);
        cyc();
        chk_fh("run0", 1'b0, 1'b0);
        chk("run0.pc", bus_if.pc_o, 32'h0);
        cyc(); chk("run.pc4", bus_if.pc_o, 32'h4);
        cyc(); chk("run.pc8", bus_if.pc_o, 32'h8);
        cyc(); chk("run.pcC", bus_if.pc_o, 32'hC);
        cyc(); chk("run.pc10", bus_if.pc_o, 32'h10);

        // Aligned jump
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        chk_fh("jmp.n", 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("jmp.pc", bus_if.pc_o, 32'h100);
        chk("jmp.mis", 32'(bus_if.misalign_o), 32'h0);
        chk_fh("jmp.n1", 1'b1, 1'b0);
        cyc();
        chk("jmp.pc2", bus_if.pc_o, 32'h104);
        chk_fh("jmp.n2", 1'b0, 1'b0);

        // Misaligned jump
        drive(1'b1, 32'h202, 1'b0, 1'b0);
        chk_fh("mis.n", 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("mis.pc", bus_if.pc_o, 32'h200);
        chk("mis.pulse", 32'(bus_if.misalign_o), 32'h1);
        cyc();
        chk("mis.pc2", bus_if.pc_o, 32'h204);
        chk("mis.end", 32'(bus_if.misalign_o), 32'h0);

        // Reach pc 0x20 then EX hold for three cycles
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(); chk("hold.pre1C", bus_if.pc_o, 32'h1C);
        cyc(); chk("hold.pre20", bus_if.pc_o, 32'h20);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk_fh("hold.c", 1'b0, 1'b1);
            chk("hold.pc", bus_if.pc_o, 32'h20);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("hold.after", bus_if.pc_o, 32'h20);
        chk_fh("hold.rel", 1'b0, 1'b0);
        cyc();
        chk("hold.resume", bus_if.pc_o, 32'h24);

        // Jump and EX hold are ignored while flushing
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h500, 1'b1, 1'b0);
        chk("fl.pc", bus_if.pc_o, 32'h300);
        chk_fh("fl.ign", 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl.pc2", bus_if.pc_o, 32'h304);
        chk_fh("fl.run", 1'b0, 1'b0);

        // Bus stall with deferred redirect; later and concurrent requests dropped
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk_fh("bh.1", 1'b0, 1'b1);
        cyc();
        drive(1'b1, 32'h400, 1'b0, 1'b1);
        chk_fh("bh.2", 1'b0, 1'b1);
        chk("bh.pc2", bus_if.pc_o, 32'h304);
        cyc();
        drive(1'b1, 32'h800, 1'b0, 1'b1);
        chk("bh.pc3", bus_if.pc_o, 32'h304);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        chk("bh.pc4", bus_if.pc_o, 32'h304);
        drive(1'b1, 32'h900, 1'b0, 1'b0);
        chk_fh("bh.rel", 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bh.tgt", bus_if.pc_o, 32'h400);
        chk_fh("bh.fl", 1'b1, 1'b0);
        cyc();
        chk("bh.tgt4", bus_if.pc_o, 32'h404);
        chk_fh("bh.run", 1'b0, 1'b0);
        cyc();
        chk("bh.single", bus_if.pc_o, 32'h408);

        // PC wrap
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap.top", bus_if.pc_o, 32'hFFFF_FFFC);
        cyc();
        chk("wrap.zero", bus_if.pc_o, 32'h0);
        cyc();
        chk("wrap.four", bus_if.pc_o, 32'h4);

        // Reset in FLUSH with a pending redirect latched
        drive(1'b1, 32'h1000, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h2000, 1'b0, 1'b1);
        chk("mrst.pc", bus_if.pc_o, 32'h1000);
        chk_fh("mrst.bh", 1'b0, 1'b1);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_fh("mrst.asrt", 1'b1, 1'b1);
        cyc();
        rst = 1'b1;
        chk("mrst.pc0", bus_if.pc_o, 32'h0);
        chk_fh("mrst.boot1", 1'b1, 1'b1);
        cyc();
        chk_fh("mrst.boot2", 1'b1, 1'b1);
        cyc();
        chk("mrst.run", bus_if.pc_o, 32'h0);
        chk_fh("mrst.nopend", 1'b0, 1'b0);
        cyc();
        chk("mrst.pc4", bus_if.pc_o, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
